// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Purpose  : APU frame sequencer; 8-step tick sequence driving length, sweep
//            and envelope clocks. Define FRAME_SEQ_EXT_TICK_EN to tick on
//            falling edges of an external DIV bit instead of the prescaler.
// Revision : 1.0
// ============================================================================
module frame_sequencer #(
  parameter int DIVISOR = 8192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_en,
`ifdef FRAME_SEQ_EXT_TICK_EN
  input  logic       div_bit,
`endif
  output logic       len_clk,
  output logic       sweep_clk,
  output logic       env_clk,
  output logic [2:0] step
);

  logic tick;

`ifdef FRAME_SEQ_EXT_TICK_EN
  // History tracks div_bit even while disabled so enabling never fakes an edge.
  logic div_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_prev <= 1'b0;
    end else begin
      div_prev <= div_bit;
    end
  end

  assign tick = apu_en & div_prev & ~div_bit;
`else
  localparam logic [15:0] LAST = 16'(DIVISOR - 1);

  logic [15:0] prescaler;

  assign tick = apu_en && (prescaler == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= 16'd0;
    end else if (!apu_en || tick) begin
      prescaler <= 16'd0;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step      <= 3'd0;
      len_clk   <= 1'b0;
      sweep_clk <= 1'b0;
      env_clk   <= 1'b0;
    end else if (!apu_en) begin
      step      <= 3'd0;
      len_clk   <= 1'b0;
      sweep_clk <= 1'b0;
      env_clk   <= 1'b0;
    end else begin
      // Pulses decode the step being executed, i.e. the value before increment.
      len_clk   <= tick && !step[0];
      sweep_clk <= tick && (step[1:0] == 2'b10);
      env_clk   <= tick && (step == 3'd7);
      if (tick) begin
        step <= step + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sequencer
// Purpose  : Self-checking scoreboard bench for frame_sequencer (DIVISOR=8).
// Revision : 1.0
// ============================================================================
module tb_frame_sequencer;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       apu_en = 1'b0;
  logic       len_clk, sweep_clk, env_clk;
  logic [2:0] step;
`ifdef FRAME_SEQ_EXT_TICK_EN
  logic       div_bit = 1'b0;
  logic       m_div_prev = 1'b0;
  int         cyc = 0;
`endif

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  int tcnt   = 0;
  int n_len = 0, n_sweep = 0, n_env = 0;
  logic [5:0] exp_q[$];

  frame_sequencer #(.DIVISOR(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .apu_en    (apu_en),
`ifdef FRAME_SEQ_EXT_TICK_EN
    .div_bit   (div_bit),
`endif
    .len_clk   (len_clk),
    .sweep_clk (sweep_clk),
    .env_clk   (env_clk),
    .step      (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {len_clk, sweep_clk, env_clk, step};
  endfunction

  // One clock: model the edge, push the expectation, then compare after the edge.
  task automatic cycle(input string tag);
    logic [5:0] e;
    logic       tk;
    int         s;
    @(posedge clk);
    e = 6'd0;
    if (!rst_n || !apu_en) begin
      en_cnt = 0;
      tcnt   = 0;
    end else begin
      en_cnt++;
`ifdef FRAME_SEQ_EXT_TICK_EN
      tk = m_div_prev && !div_bit;
`else
      tk = (en_cnt % DIV) == 0;
`endif
      if (tk) begin
        s    = tcnt % 8;
        tcnt = tcnt + 1;
        e[5] = (s % 2) == 0;
        e[4] = (s == 2) || (s == 6);
        e[3] = (s == 7);
      end
      e[2:0] = 3'(tcnt % 8);
    end
`ifdef FRAME_SEQ_EXT_TICK_EN
    m_div_prev = rst_n ? div_bit : 1'b0;
`endif
    exp_q.push_back(e);
    #1;
    check(tag, {26'd0, outs()}, {26'd0, exp_q.pop_front()});
    n_len   += int'(len_clk);
    n_sweep += int'(sweep_clk);
    n_env   += int'(env_clk);
`ifdef FRAME_SEQ_EXT_TICK_EN
    cyc++;
    div_bit = ((cyc / 4) % 2) == 1;
`endif
  endtask

  initial begin
    #3;
    check("reset_state", {26'd0, outs()}, 32'd0);
    repeat (2) cycle("in_reset");
    rst_n = 1'b1;

`ifdef FRAME_SEQ_EXT_TICK_EN
    // Enable only while div_bit is low; the first tick follows the next 1->0.
    while (div_bit) cycle("wait_low");
    apu_en = 1'b1;
    n_len = 0;
    repeat (64) cycle("ext_seq");
    check("ext_len_count", n_len, 32'd4);
    apu_en = 1'b0;
    repeat (5) cycle("ext_off");
    apu_en = 1'b1;
    repeat (40) cycle("ext_reen");
`else
    apu_en = 1'b1;
    repeat (DIV - 1) cycle("pre_tick");
    check("no_early_len", {31'd0, len_clk}, 32'd0);
    cycle("first_tick");
    check("first_len", {31'd0, len_clk}, 32'd1);
    check("first_step", {29'd0, step}, 32'd1);

    // 64 ticks total from enable.
    n_len = 1; n_sweep = 0; n_env = 0;
    repeat (63 * DIV) cycle("run64");
    cycle("settle");
    check("len_count", n_len, 32'd32);
    check("sweep_count", n_sweep, 32'd16);
    check("env_count", n_env, 32'd8);
    check("wrap_step", {29'd0, step}, 32'd0);

    // Disable mid-frame after 3 ticks plus 5 cycles.
    apu_en = 1'b0;
    cycle("clear");
    apu_en = 1'b1;
    repeat (3 * DIV + 5) cycle("pre_drop");
    apu_en = 1'b0;
    n_len = 0; n_sweep = 0; n_env = 0;
    repeat (10) cycle("disabled");
    check("off_step", {29'd0, step}, 32'd0);
    check("off_pulses", n_len + n_sweep + n_env, 32'd0);
    apu_en = 1'b1;
    repeat (DIV - 1) cycle("reen_wait");
    check("reen_quiet", n_len, 32'd0);
    cycle("reen_tick");
    check("reen_len", {31'd0, len_clk}, 32'd1);

    // Asynchronous reset in the middle of a pulse.
    apu_en = 1'b0;
    cycle("clear2");
    apu_en = 1'b1;
    repeat (DIV) cycle("pre_rst");
    check("pulse_before_rst", {31'd0, len_clk}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("async_rst", {26'd0, outs()}, 32'd0);
    repeat (3) cycle("rst_held");
    rst_n = 1'b1;
    repeat (2 * DIV) cycle("post_rst");
    check("post_rst_step", {29'd0, step}, 32'd2);

    // Random enable drops.
    for (int i = 0; i < 300; i++) begin
      apu_en = ($urandom_range(0, 15) != 0);
      cycle("random");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
